// File: rtl/aes_sub_bytes_pipe.sv
// aes_sub_bytes_pipe
// Pipelined SubBytes / InvSubBytes engine. Each transaction carries LANES bytes
// and a mode bit; every byte is substituted through the AES forward S-box
// (mode 0) or the inverse S-box (mode 1). Valid/ready on both sides with full
// backpressure; the mode travels through the pipeline alongside its data.
//
// Parameters
//   LANES    bytes per transaction, 1..16
//   LATENCY  pipeline stages, 1 (lookup before stage 1) or 2 (lookup between
//            stage 1 and stage 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset, clears all in-flight work
//   in_valid   input transaction present
//   in_ready   stage 1 can load this cycle (combinational from out_ready)
//   in_mode    0 = forward S-box, 1 = inverse S-box
//   in_data    lane i = in_data[8*i+7:8*i]
//   out_valid  output transaction present
//   out_ready  downstream accepts output this cycle
//   out_mode   mode of the transaction on out_data
//   out_data   substituted bytes, lane order preserved
module aes_sub_bytes_pipe #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [8*LANES-1:0]   out_data
);

    localparam int unsigned W = 8 * LANES;

    // Parameter range guards
    if (LANES == 0 || LANES > 16) begin : g_bad_lanes
        $error("aes_sub_bytes_pipe: LANES=%0d is outside 1..16", LANES);
    end

    // Forward S-box, entry 0 first
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 first
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Per-lane substitution, all lanes share the transaction mode
    function automatic logic [W-1:0] sub_lanes(input logic mode, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            r[8*i +: 8] = mode ? INV_SBOX[d[8*i +: 8]] : FWD_SBOX[d[8*i +: 8]];
        end
        return r;
    endfunction

    if (LATENCY == 1) begin : g_lat1
        logic         s1_v;
        logic         s1_m;
        logic [W-1:0] s1_d;
        logic         s1_ld_c;

        // Single stage loads when empty or when the output is being taken
        assign s1_ld_c = !s1_v || out_ready;

        // Lookup on the input side, result registered
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_v <= 1'b0;
                s1_m <= 1'b0;
                s1_d <= '0;
            end else if (s1_ld_c) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_m <= in_mode;
                    s1_d <= sub_lanes(in_mode, in_data);
                end
            end
        end

        assign in_ready  = s1_ld_c;
        assign out_valid = s1_v;
        assign out_mode  = s1_m;
        assign out_data  = s1_d;
    end else if (LATENCY == 2) begin : g_lat2
        logic         s1_v;
        logic         s1_m;
        logic [W-1:0] s1_d;
        logic         s2_v;
        logic         s2_m;
        logic [W-1:0] s2_d;
        logic         s1_ld_c;
        logic         s2_ld_c;

        // Load enables ripple back from the output so a full pipe still streams
        assign s2_ld_c = !s2_v || out_ready;
        assign s1_ld_c = !s1_v || s2_ld_c;

        // Stage 1 holds raw input bytes
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_v <= 1'b0;
                s1_m <= 1'b0;
                s1_d <= '0;
            end else if (s1_ld_c) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_m <= in_mode;
                    s1_d <= in_data;
                end
            end
        end

        // Stage 2 holds substituted bytes
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_v <= 1'b0;
                s2_m <= 1'b0;
                s2_d <= '0;
            end else if (s2_ld_c) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_m <= s1_m;
                    s2_d <= sub_lanes(s1_m, s1_d);
                end
            end
        end

        assign in_ready  = s1_ld_c;
        assign out_valid = s2_v;
        assign out_mode  = s2_m;
        assign out_data  = s2_d;
    end else begin : g_bad_latency
        $error("aes_sub_bytes_pipe: LATENCY=%0d must be 1 or 2", LATENCY);
    end

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// tb_aes_sub_bytes_pipe
// Two instances (LANES=16, LATENCY=1 and LATENCY=2) exercised one at a time.
// Stimulus pushes expected results into a queue; a negedge monitor pops and
// compares whenever the selected instance transfers an output. Reference
// S-boxes are derived from GF(2^8) inversion plus the affine transform.
`timescale 1ns/1ps
module tb_aes_sub_bytes_pipe;

    localparam int unsigned LANES = 16;
    localparam int unsigned W     = 8 * LANES;

    typedef struct packed {
        logic         mode;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv = 1'b0;
    logic         im = 1'b0;
    logic [W-1:0] id = '0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;

    logic [1:0]   in_ready_w;
    logic [1:0]   out_valid_w;
    logic [1:0]   out_mode_w;
    logic [W-1:0] out_data_w [2];

    logic         ov, ir, om;
    logic [W-1:0] od;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    exp_t         q[$];
    int           pop_cyc[$];
    int           cyc = 0;
    int           acc_cyc = 0;
    int           nchk = 0;
    int           nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes_sub_bytes_pipe #(.LANES(LANES), .LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv && (sel == 1'(g))),
            .in_ready  (in_ready_w[g]),
            .in_mode   (im),
            .in_data   (id),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_mode  (out_mode_w[g]),
            .out_data  (out_data_w[g])
        );
    end

    assign ov = out_valid_w[sel];
    assign ir = in_ready_w[sel];
    assign om = out_mode_w[sel];
    assign od = out_data_w[sel];

    task automatic chk(input string name, input logic ok, input logic [W:0] act, input logic [W:0] req);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] s, t;
        s = b;
        t = b;
        for (int i = 0; i < 4; i++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [W-1:0] exp_lanes(input logic m, input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < int'(LANES); i++)
            r[8*i +: 8] = m ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] bp_vec(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < int'(LANES); i++) r[8*i +: 8] = 8'(k * 16 + i + 64);
        return r;
    endfunction

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: scoreboard compare on transfer, stability while stalled
    initial begin : monitor
        exp_t         e;
        logic         stall;
        logic [W-1:0] pd;
        logic         pm;
        stall = 1'b0;
        pd = '0;
        pm = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (ov && stall)
                    chk("hold_stable", {om, od} == {pm, pd}, {om, od}, {pm, pd});
                if (ov && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1'b0, {om, od}, '0);
                    end else begin
                        e = q.pop_front();
                        chk("out", {om, od} == e, {om, od}, e);
                    end
                    pop_cyc.push_back(cyc);
                end
                stall = ov && !out_ready;
                pd = od;
                pm = om;
            end
        end
    end

    // Drive one transaction; called and returns at posedge+1
    task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] e);
        int   n;
        exp_t x;
        n  = 0;
        iv = 1'b1;
        im = m;
        id = d;
        @(negedge clk);
        while (!ir && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ir) begin
            chk("accept_timeout", 1'b0, 129'(0), 129'(1));
        end else begin
            x = {m, e};
            q.push_back(x);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(q.size() == 0 && !ov) && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) chk("drain_timeout", 1'b0, 129'(q.size()), 129'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic run_suite(input logic s);
        logic [W-1:0] v_in_f, v_out_f, d, e;
        int           t0, acc, k, sent;
        logic         acc_flag;
        exp_t         x;
        int           lat;

        sel = s;
        lat = int'(s) + 1;
        #1;
        v_in_f  = {96'h0, 32'hff530100};
        v_out_f = {{12{8'h63}}, 32'h16ed7c63};

        // Forward vector and latency
        out_ready = 1'b1;
        pop_cyc.delete();
        send(1'b0, v_in_f, v_out_f);
        t0 = acc_cyc;
        wait_drain();
        chk("latency", pop_cyc.size() == 1 && pop_cyc[0] - t0 == lat,
            129'(pop_cyc[0] - t0), 129'(lat));

        // Fwd/inv/fwd interleaved back-to-back
        pop_cyc.delete();
        send(1'b0, v_in_f, v_out_f);
        send(1'b1, v_out_f, v_in_f);
        send(1'b0, v_in_f, v_out_f);
        wait_drain();
        chk("interleave_no_bubble", pop_cyc.size() == 3 && pop_cyc[2] - pop_cyc[0] == 2,
            129'(pop_cyc[2] - pop_cyc[0]), 129'(2));

        // Exhaustive byte coverage in both modes and round trip
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * t + i);
            send(1'b0, d, exp_lanes(1'b0, d));
            send(1'b1, d, exp_lanes(1'b1, d));
            for (int i = 0; i < 16; i++) e[8*i +: 8] = fwd_tab[d[8*i +: 8]];
            send(1'b1, e, d);
        end
        wait_drain();

        // Backpressure: capacity, then drain, then full rate
        out_ready = 1'b0;
        acc = 0;
        k = 0;
        iv = 1'b1;
        im = 1'b0;
        id = bp_vec(k);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ir) begin
                x = {1'b0, exp_lanes(1'b0, id)};
                q.push_back(x);
                acc++;
                k++;
            end
            @(posedge clk);
            #1;
            id = bp_vec(k);
        end
        iv = 1'b0;
        chk("capacity", acc == lat, 129'(acc), 129'(lat));
        chk("full_in_ready_low", ir == 1'b0, 129'(ir), 129'(0));
        out_ready = 1'b1;
        wait_drain();
        pop_cyc.delete();
        for (int j = 0; j < 8; j++) begin
            d = bp_vec(j + 20);
            send(1'(j), d, exp_lanes(1'(j), d));
        end
        wait_drain();
        chk("throughput", pop_cyc.size() == 8 && pop_cyc[7] - pop_cyc[0] == 7,
            129'(pop_cyc[7] - pop_cyc[0]), 129'(7));

        // Random valid/ready toggling
        sent = 0;
        acc_flag = 1'b0;
        for (int c = 0; c < 40000 && sent < 5000; c++) begin
            if (acc_flag) iv = 1'b0;
            acc_flag = 1'b0;
            out_ready = ($urandom_range(0, 99) < 70);
            if (!iv && $urandom_range(0, 99) < 70) begin
                iv = 1'b1;
                im = 1'($urandom_range(0, 1));
                id = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (iv && ir) begin
                x = {im, exp_lanes(im, id)};
                q.push_back(x);
                sent++;
                acc_flag = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        chk("random_sent", sent == 5000, 129'(sent), 129'(5000));
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with the pipeline full
        out_ready = 1'b0;
        for (int j = 0; j < lat; j++) begin
            d = bp_vec(j + 40);
            send(1'b0, d, exp_lanes(1'b0, d));
        end
        chk("inflight_valid", ov == 1'b1, 129'(ov), 129'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", ov == 1'b0, 129'(ov), 129'(0));
        chk("rst_in_ready", ir == 1'b1, 129'(ir), 129'(1));
        q.delete();
        pop_cyc.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(1'b0, v_in_f, v_out_f);
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_count", pop_cyc.size() == 1, 129'(pop_cyc.size()), 129'(1));
    endtask

    initial begin : main
        logic [7:0] b, p;
        for (int xv = 0; xv < 256; xv++) begin
            b = 8'(xv);
            p = 8'h01;
            for (int j = 0; j < 254; j++) p = gmul(p, b);
            fwd_tab[xv] = affine(p);
        end
        for (int xv = 0; xv < 256; xv++) inv_tab[fwd_tab[xv]] = 8'(xv);

        // Reset values on both instances
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_out_valid", out_valid_w[g] == 1'b0, 129'(out_valid_w[g]), 129'(0));
            chk("reset_out_data", out_data_w[g] == '0, {1'b0, out_data_w[g]}, 129'(0));
            chk("reset_out_mode", out_mode_w[g] == 1'b0, 129'(out_mode_w[g]), 129'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready_w == 2'b11, 129'(in_ready_w), 129'(3));
        @(posedge clk);
        #1;

        run_suite(1'b0);
        run_suite(1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_pipe.md
# aes_sub_bytes_pipe

Parametrised, pipelined SubBytes/InvSubBytes engine. Substitutes LANES bytes per transaction through the AES forward S-box or inverse S-box, selected per transaction. Valid/ready handshakes on both sides and full backpressure support. Sits between the round-state register and ShiftRows in the shared encrypt/decrypt datapath, and replaces per-byte combinational lookups.

## Interface

Parameters:
- LANES, 4, bytes substituted per transaction; legal 1..16 (16 = full AES state).
- LATENCY, 1, pipeline stages from input acceptance to output valid; legal 1 or 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept input this cycle.
- in_mode  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt).
- in_data  input  8*LANES  bytes to substitute; lane i = in_data[8*i+7:8*i].
- out_valid  output  1  output transaction present.
- out_ready  input  1  downstream accepts output this cycle.
- out_mode  output  1  in_mode of the transaction on out_data.
- out_data  output  8*LANES  substituted bytes, lane order preserved.

## Operation

- Transfer on a port occurs when its valid and ready are both high at a clock edge.
- Each lane is independent: out lane i = SBOX(in lane i) if mode = 0, INV_SBOX(in lane i) if mode = 1. The tables are the FIPS-197 forward and inverse S-boxes, built as internal 256-entry constant lookups.
- Mode is captured with the data and travels with it. Transactions of different modes may be interleaved back-to-back with no bubble.
- Pipeline: LATENCY stages, each holding valid, mode and 8*LANES data.
  - LATENCY = 1: the lookup is done on in_data, and the result is registered in stage 1.
  - LATENCY = 2: stage 1 registers raw input and mode; the lookup is done between stage 1 and stage 2.
- Stall rule, applied per stage: stage k loads when it is empty or when stage k+1 (or the output, for the last stage) is taking its content this cycle. Otherwise stage k holds its value.
- in_ready is high when stage 1 can load this cycle. It is combinational from out_ready and the stage valids, so a full pipeline with out_ready = 1 accepts one transaction per cycle.
- No transaction is dropped, duplicated or reordered under any valid/ready pattern.
- out_data and out_mode stay stable while out_valid = 1 and out_ready = 0.
- in_data and in_mode are ignored when in_valid = 0. Stage data registers need not be reset; stage valid bits must be.

## Timing

- Reset values:
  - out_valid = 0, all stage valid bits = 0.
  - out_data = 0 and out_mode = 0 (data registers reset to 0 for determinism).
  - in_ready = 1 from the first cycle after reset deassertion.
- Latency: a transaction accepted at edge N appears with out_valid = 1 in the cycle after edge N+LATENCY-1. This is 1 cycle for LATENCY = 1 and 2 cycles for LATENCY = 2, with no backpressure.
- Throughput: 1 transaction per cycle sustained while out_ready = 1.
- Capacity: LATENCY transactions in flight. With out_ready held low, in_ready falls after exactly LATENCY acceptances.
- Simultaneous output consume and input accept on a full pipeline: both occur in the same cycle and occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are discarded immediately and asynchronously. out_valid drops without waiting for a clock edge. No stale output appears after reset release.
- Out-of-range parameters (LANES outside 1..16, LATENCY not 1 or 2) stop elaboration with an error.

## Test plan

- Forward, LANES = 4, LATENCY = 1: in_data = 0xff_53_01_00, mode 0 -> one cycle later out_data = 0x16_ed_7c_63, out_mode = 0.
- Inverse, same config: in_data = 0x16_ed_7c_63, mode 1 -> out_data = 0xff_53_01_00. Interleave fwd/inv/fwd back-to-back -> three results in order, each with the correct out_mode, no bubbles.
- Exhaustive, LANES = 16, both LATENCY values: stream all 256 byte values in both modes -> every lane matches the FIPS-197 tables, and INV(FWD(x)) = x for all x.
- Backpressure, LATENCY = 2: out_ready = 0 with continuous in_valid -> exactly 2 accepted, then in_ready = 0 and out_data stable. Release out_ready -> both drain in order, then 1 transaction per cycle.
- Random valid/ready toggling for 10k transactions against a scoreboard -> no loss, duplication or reordering.
- Assert rst with 2 transactions in flight -> out_valid = 0 and in_ready = 1 immediately. After release, the first output is the first post-reset input.
